// File: rtl/core_pkg.sv
// core_pkg: shared core-wide widths, reset constants and fetch data types.
//   XLEN / INSTR_W    : architectural register and instruction widths
//   DEFAULT_RESET_PC  : first fetch address after reset
//   fetch_word_t      : one fetched instruction together with its address
//   word_align        : clears the byte-offset bits of a byte address
// The instruction memory is word addressed: a byte address maps to
// word address addr[IMEM_AW+1:2] for an IMEM_AW-bit word address.
package core_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    pc;
    } fetch_word_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory read port plus the fetch-to-decode handshake.
//   imem_en / imem_addr / imem_rdata : synchronous memory, 1-cycle read latency
//   valid / ready                    : fetch-to-decode handshake
//   instr / pc / pcplus4             : fetched word, its address, address + 4
// master = fetch side, slave = memory/decode side.
interface fetch_unit_if
    import core_pkg::*;
#(
    parameter int IMEM_AW = 14
) ();

    logic               imem_en;
    logic [IMEM_AW-1:0] imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               valid;
    logic               ready;
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    pcplus4;

    modport master (
        output imem_en, imem_addr, valid, instr, pc, pcplus4,
        input  imem_rdata, ready
    );

    modport slave (
        input  imem_en, imem_addr, valid, instr, pc, pcplus4,
        output imem_rdata, ready
    );

endinterface

// File: rtl/fetch_unit_hold.sv
// fetch_unit_hold: one-entry hold register keeping a fetched word while decode stalls.
//   clk, rstn : clock, synchronous active-low reset
//   i_load    : capture i_word and mark the entry valid
//   i_clear   : invalidate the entry (wins over i_load)
//   i_word    : word to capture
//   o_valid   : entry holds a word
//   o_word    : held word
module fetch_unit_hold
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_load,
    input  logic        i_clear,
    input  fetch_word_t i_word,
    output logic        o_valid,
    output fetch_word_t o_word
);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            o_valid <= 1'b0;
            o_word  <= '0;
        end else if (i_clear) begin
            o_valid <= 1'b0;
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_word  <= i_word;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage owning the PC, the memory read issue and the decode handshake.
//   clk, rstn     : clock, synchronous active-low reset
//   i_redirect    : restart fetch at i_redirect_pc, overriding everything else
//   i_redirect_pc : redirect target byte address (low two bits ignored)
//   bus           : memory read port and decode handshake (master side)
module fetch_unit
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int              IMEM_AW  = 14
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    fetch_unit_if.master    bus
);

    logic [XLEN-1:0] r_pc;
    logic            r_req_v;
    logic [XLEN-1:0] r_req_pc;
    logic            w_hold_v;
    fetch_word_t     w_hold_word;
    fetch_word_t     w_mem_word;
    logic            w_valid;
    logic            w_mem_v;
    logic            w_issue;
    logic            w_load;
    logic            w_clear;
    logic [XLEN-1:0] w_issue_pc;

    // A redirect squashes whatever would be presented this cycle.
    assign w_valid    = rstn & ~i_redirect & (w_hold_v | r_req_v);
    assign w_mem_v    = r_req_v & ~w_hold_v;
    assign w_issue    = i_redirect | bus.ready | ~w_valid;
    assign w_issue_pc = i_redirect ? word_align(i_redirect_pc) : r_pc;
    // Capture only a live memory word that decode refused; that cycle issues nothing.
    assign w_load     = w_mem_v & ~bus.ready & ~i_redirect;
    assign w_clear    = i_redirect | (w_hold_v & bus.ready);
    assign w_mem_word = '{instr: bus.imem_rdata, pc: r_req_pc};

    assign bus.imem_en   = w_issue & rstn;
    assign bus.imem_addr = w_issue_pc[IMEM_AW+1:2];
    assign bus.valid     = w_valid;
    assign bus.instr     = w_hold_v ? w_hold_word.instr : r_req_v ? bus.imem_rdata : '0;
    assign bus.pc        = w_hold_v ? w_hold_word.pc : r_req_v ? r_req_pc : '0;
    assign bus.pcplus4   = bus.pc + 32'd4;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_pc     <= RESET_PC;
            r_req_v  <= 1'b0;
            r_req_pc <= '0;
        end else begin
            r_req_v <= w_issue;
            if (w_issue) begin
                r_pc     <= w_issue_pc + 32'd4;
                r_req_pc <= w_issue_pc;
            end
        end
    end

    fetch_unit_hold u_hold (
        .clk     (clk),
        .rstn    (rstn),
        .i_load  (w_load),
        .i_clear (w_clear),
        .i_word  (w_mem_word),
        .o_valid (w_hold_v),
        .o_word  (w_hold_word)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed cycle-by-cycle vectors for fetch_unit against a synchronous memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    fetch_unit_if #(.IMEM_AW(14)) bus ();

    fetch_unit #(.RESET_PC(32'h0), .IMEM_AW(14)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .bus           (bus)
    );

    function automatic logic [31:0] instr_of(input logic [13:0] a);
        return 32'hC0DE_0000 | {18'd0, a};
    endfunction

    always @(posedge clk) if (bus.imem_en) bus.imem_rdata <= instr_of(bus.imem_addr);

    typedef struct {
        logic        rstn;
        logic        rd;
        logic [31:0] rpc;
        logic        rdy;
        logic        en;
        logic [13:0] addr;
        logic        v;
        logic [31:0] pc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rs, input logic rd, input logic [31:0] rpc, input logic rdy,
                       input logic en, input logic [13:0] addr, input logic v, input logic [31:0] pc);
        vec_t e;
        e = '{rstn: rs, rd: rd, rpc: rpc, rdy: rdy, en: en, addr: addr, v: v, pc: pc};
        tbl.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rs, input logic rd, input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        rstn        = rs;
        redirect    = rd;
        redirect_pc = rpc;
        bus.ready   = rdy;
        #1;
    endtask

    initial begin
        int lat;
        bus.ready = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk("reset valid", {31'd0, bus.valid}, 32'd0);
        chk("reset en", {31'd0, bus.imem_en}, 32'd0);
        chk("reset pc", bus.pc, 32'h0);
        chk("reset instr", bus.instr, 32'h0);

        add(1, 0, 0, 1, 1, 14'h0000, 0, 0);
        add(1, 0, 0, 1, 1, 14'h0001, 1, 32'h0);
        add(1, 0, 0, 1, 1, 14'h0002, 1, 32'h4);
        add(1, 0, 0, 0, 0, 14'h0000, 1, 32'h8);
        add(1, 0, 0, 0, 0, 14'h0000, 1, 32'h8);
        add(1, 0, 0, 0, 0, 14'h0000, 1, 32'h8);
        add(1, 0, 0, 1, 1, 14'h0003, 1, 32'h8);
        add(1, 0, 0, 1, 1, 14'h0004, 1, 32'hC);
        add(1, 0, 0, 0, 0, 14'h0000, 1, 32'h10);
        add(1, 1, 32'h0000_0103, 0, 1, 14'h0040, 0, 0);
        add(1, 0, 0, 1, 1, 14'h0041, 1, 32'h100);
        add(1, 1, 32'h0000_0200, 0, 1, 14'h0080, 0, 0);
        add(1, 0, 0, 1, 1, 14'h0081, 1, 32'h200);
        add(1, 1, 32'hFFFF_FFFC, 1, 1, 14'h3FFF, 0, 0);
        add(1, 0, 0, 1, 1, 14'h0000, 1, 32'hFFFF_FFFC);
        add(1, 0, 0, 1, 1, 14'h0001, 1, 32'h0);
        add(1, 0, 0, 1, 1, 14'h0002, 1, 32'h4);
        add(1, 0, 0, 0, 0, 14'h0000, 1, 32'h8);
        add(1, 0, 0, 0, 0, 14'h0000, 1, 32'h8);
        add(0, 0, 0, 0, 0, 14'h0000, 0, 0);
        add(1, 0, 0, 1, 1, 14'h0000, 0, 0);
        add(1, 0, 0, 1, 1, 14'h0001, 1, 32'h0);

        foreach (tbl[i]) begin
            drive(tbl[i].rstn, tbl[i].rd, tbl[i].rpc, tbl[i].rdy);
            chk($sformatf("v%0d valid", i), {31'd0, bus.valid}, {31'd0, tbl[i].v});
            chk($sformatf("v%0d en", i), {31'd0, bus.imem_en}, {31'd0, tbl[i].en});
            if (tbl[i].en) chk($sformatf("v%0d addr", i), {18'd0, bus.imem_addr}, {18'd0, tbl[i].addr});
            if (tbl[i].v) begin
                chk($sformatf("v%0d pc", i), bus.pc, tbl[i].pc);
                chk($sformatf("v%0d pcplus4", i), bus.pcplus4, tbl[i].pc + 32'd4);
                chk($sformatf("v%0d instr", i), bus.instr, instr_of(tbl[i].pc[15:2]));
            end
        end

        drive(1'b1, 1'b1, 32'h0000_0302, 1'b1);
        chk("redir valid", {31'd0, bus.valid}, 32'd0);
        chk("redir addr", {18'd0, bus.imem_addr}, 32'h0000_00C0);
        lat = 0;
        do begin
            drive(1'b1, 1'b0, 32'h0, 1'b1);
            lat++;
        end while (!bus.valid && lat < 8);
        chk("redir latency", lat, 1);
        chk("redir target pc", bus.pc, 32'h0000_0300);
        chk("redir target instr", bus.instr, instr_of(14'h00C0));

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the core. Owns the program counter, issues word reads to a synchronous instruction memory with 1-cycle read latency, and presents fetched instructions to decode over a valid/ready handshake. A one-entry hold buffer preserves a fetched word while decode stalls. Branch, jump and exception redirects from downstream restart fetch at a new PC.

## Interface
- RESET_PC, 32'h0000_0000: address of the first fetch after reset.
- IMEM_AW, 14: instruction-memory word-address width.

- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- redirect_i  in  1  restart fetch at redirect_pc_i; has priority over everything else.
- redirect_pc_i  in  32  redirect target; bits [1:0] are forced to 0.
- imem_en_o  out  1  read enable to instruction memory.
- imem_addr_o  out  IMEM_AW  word address, equal to issue_pc[IMEM_AW+1:2].
- imem_rdata_i  in  32  read data, valid one cycle after imem_en_o.
- valid_o  out  1  instr_o, pc_o and pcplus4_o are valid.
- ready_i  in  1  decode accepts the word this cycle.
- instr_o  out  32  fetched instruction.
- pc_o  out  32  address of instr_o.
- pcplus4_o  out  32  pc_o + 4, modulo 2^32.

## Operation
- State:
  - pc_q: next sequential fetch address.
  - req_v_q and req_pc_q: a read was issued last cycle.
  - hold_v_q, hold_instr_q and hold_pc_q: the hold buffer.
- Output source:
  - If hold_v_q is set, outputs come from the hold buffer.
  - Otherwise, if req_v_q is set, outputs are imem_rdata_i with req_pc_q.
  - Otherwise valid_o is 0.
- valid_o is forced to 0 in any cycle where redirect_i is 1.
- A transfer occurs when valid_o and ready_i are both 1.
- issue = redirect_i | ready_i | ~valid_o. imem_en_o = issue & rstn.
- issue_pc = redirect_i ? {redirect_pc_i[31:2], 2'b00} : pc_q.
- On issue: pc_q <= issue_pc + 4; req_v_q <= 1; req_pc_q <= issue_pc.
- Without issue: req_v_q <= 0 and pc_q is unchanged.
- Hold capture: if valid_o is sourced from memory and ready_i is 0, load the word into the hold buffer (hold_v_q <= 1). No issue happens that cycle.
- Hold release: if hold_v_q is set and ready_i is 1, set hold_v_q <= 0. A new read issues in the same cycle.
- Redirect: clear hold_v_q, discard the in-flight response (it is never presented), and issue at the target in the same cycle.
- PC arithmetic is 32-bit unsigned and wraps: 32'hFFFF_FFFC + 4 = 0. The address wraps modulo 2^IMEM_AW words.
- Steady state has two states, STREAM (hold empty) and HELD (hold full):
  - STREAM -> HELD on stall.
  - HELD -> STREAM on ready_i or redirect_i.

## Timing
- Reset values: pc_q = RESET_PC; req_v_q, hold_v_q = 0; valid_o, imem_en_o = 0; instr_o, pc_o, hold registers = 0.
- Start-up: in the first cycle with rstn high, the read at RESET_PC issues. valid_o rises in the next cycle.
- Fetch-to-valid latency is 1 cycle.
- Throughput is 1 instruction per cycle while ready_i is held high.
- Redirect in cycle t: valid_o = 0 in cycle t, and the target word is valid in cycle t+1. The redirect penalty is the 1 cycle plus whatever was in flight.
- Asserting rstn low mid-stream: state returns to reset values at the next edge, and any in-flight or held word is lost.
- No combinational path from ready_i to imem_addr_o other than through issue. There is no path from imem_rdata_i to any control signal.

## Structure
- Shared package core_pkg holds:
  - XLEN = 32.
  - INSTR_W = 32.
  - the default RESET_PC constant.
  - the word-address helper width relation (byte address [IMEM_AW+1:2]).
- Natural sub-module: fetch_hold, a one-entry hold register (valid, data, pc) with load and clear inputs.
- The PC register and issue logic stay in fetch_unit.

## Test plan
- Reset release with RESET_PC = 0 and ready_i = 1 -> imem_addr_o = 0, 1, 2, … on consecutive cycles; pc_o = 0, 4, 8 with valid_o high from the second cycle.
- Stall ready_i = 0 for 3 cycles while pc_o = 8 -> instr_o and pc_o stay fixed; imem_en_o = 0 after capture; on release, pc 8 is transferred exactly once, then 12 follows.
- Redirect to 32'h0000_0103 while the hold buffer is full -> valid_o = 0 that cycle, the held word is dropped, and the next valid word has pc_o = 32'h100.
- Redirect in the same cycle as ready_i = 0 and a memory response -> the response is never presented and imem_addr_o equals the target word.
- Redirect to 32'hFFFF_FFFC -> pc_o sequence FFFF_FFFC, 0, 4 with pcplus4_o = 0 on the first word.
- rstn low for one cycle mid-stream with the hold buffer full -> valid_o = 0 next cycle; fetch resumes at RESET_PC.
